// File: rtl/term_screen_engine.sv
// term_screen_engine
//   Character-screen engine between a UART RX byte stream and a UART TX serializer.
//   Holds a ROWS x COLS screen in inferred RAM and runs a vi-like command/insert mode.
//   Cursor changes are mirrored to the host as VT100 "ESC[r;cH" sequences.
// Ports
//   clk, rst   clock, synchronous active-high reset
//   i_byte     received byte, qualified by the 1-cycle strobe i_byte_v
//   i_tx_done  serializer finished the current byte (1-cycle strobe)
//   o_byte     byte to transmit, qualified by the 1-cycle strobe o_byte_v
//   o_busy     an output sequence is in progress; input bytes are dropped meanwhile
//   o_insert   insert mode active
module term_screen_engine #(
    parameter int unsigned COLS     = 40,
    parameter int unsigned ROWS     = 24,
    parameter int unsigned ADDR_W   = 11,
    parameter int unsigned CUR_ROW0 = 7,
    parameter int unsigned CUR_COL0 = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] i_byte,
    input  logic       i_byte_v,
    input  logic       i_tx_done,
    output logic [7:0] o_byte,
    output logic       o_byte_v,
    output logic       o_busy,
    output logic       o_insert
);
    localparam logic [6:0] LAST_COL = 7'(COLS - 1);
    localparam logic [6:0] LAST_ROW = 7'(ROWS - 1);

    typedef enum logic [1:0] {StIdle, StFetch, StSend, StWait} state_e;
    // Which part of an output sequence is being sent.
    typedef enum logic [2:0] {PhEcho, PhHdr, PhCell, PhCr, PhLf, PhPos} phase_e;

    state_e            state_q, state_d;
    phase_e            ph_q, ph_nx, ph_start;
    logic [2:0]        idx_q, idx_nx;
    logic              seq_last, seq_fetch;
    logic [6:0]        row_q, col_q, row_d, col_d;
    logic              insert_q, insert_d;
    logic              pos_after_q, pos_after_d;
    logic [7:0]        echo_q;
    logic [6:0]        crow_q, ccol_q;
    logic [ADDR_W-1:0] cell_q, wr_addr;
    logic [7:0]        mem [2**ADDR_W];
    logic [7:0]        rd_data_q;
    logic              accept, start, wr_en, tx_step;
    logic [7:0]        row_num, col_num, cur_byte;

    assign accept   = i_byte_v && (state_q == StIdle);
    assign tx_step  = (state_q == StWait) && i_tx_done;
    assign row_num  = {1'b0, row_q} + 8'd1;
    assign col_num  = {1'b0, col_q} + 8'd1;
    assign wr_addr  = ADDR_W'({25'd0, row_q} * COLS + {25'd0, col_q});
    assign o_insert = insert_q;

    // Decode of an accepted input byte: cursor/mode update and which sequence to start.
    always_comb begin
        start       = 1'b0;
        ph_start    = PhPos;
        row_d       = row_q;
        col_d       = col_q;
        insert_d    = insert_q;
        wr_en       = 1'b0;
        pos_after_d = 1'b0;
        if (accept) begin
            if (!insert_q) begin
                case (i_byte)
                    8'h68: begin if (col_q != 7'd0) col_d = col_q - 7'd1; start = 1'b1; end
                    8'h6C: begin if (col_q != LAST_COL) col_d = col_q + 7'd1; start = 1'b1; end
                    8'h6B: begin if (row_q != 7'd0) row_d = row_q - 7'd1; start = 1'b1; end
                    8'h6A: begin if (row_q != LAST_ROW) row_d = row_q + 7'd1; start = 1'b1; end
                    8'h69: insert_d = 1'b1;
                    8'h20: begin start = 1'b1; ph_start = PhHdr; end
                    default: ;
                endcase
            end else if (i_byte == 8'h1B) begin
                insert_d = 1'b0;
            end else if (i_byte >= 8'h20 && i_byte <= 8'h7E) begin
                wr_en    = 1'b1;
                start    = 1'b1;
                ph_start = PhEcho;
                if (col_q == LAST_COL) begin
                    col_d       = 7'd0;
                    row_d       = (row_q == LAST_ROW) ? 7'd0 : row_q + 7'd1;
                    pos_after_d = 1'b1;
                end else begin
                    col_d = col_q + 7'd1;
                end
            end
        end
    end

    // Byte currently presented in SEND.
    always_comb begin
        cur_byte = 8'h00;
        case (ph_q)
            PhEcho: cur_byte = echo_q;
            PhHdr:  cur_byte = (idx_q == 3'd0) ? 8'h1B : (idx_q == 3'd1) ? 8'h5B : 8'h48;
            PhCell: cur_byte = rd_data_q;
            PhCr:   cur_byte = 8'h0D;
            PhLf:   cur_byte = 8'h0A;
            PhPos: begin
                case (idx_q)
                    3'd0:    cur_byte = 8'h1B;
                    3'd1:    cur_byte = 8'h5B;
                    3'd2:    cur_byte = 8'h30 + row_num / 8'd10;
                    3'd3:    cur_byte = 8'h30 + row_num % 8'd10;
                    3'd4:    cur_byte = 8'h3B;
                    3'd5:    cur_byte = 8'h30 + col_num / 8'd10;
                    3'd6:    cur_byte = 8'h30 + col_num % 8'd10;
                    default: cur_byte = 8'h48;
                endcase
            end
            default: cur_byte = 8'h00;
        endcase
    end

    // Step to the byte after the current one; tens digits below 10 are skipped.
    always_comb begin
        ph_nx     = ph_q;
        idx_nx    = idx_q;
        seq_last  = 1'b0;
        seq_fetch = 1'b0;
        case (ph_q)
            PhEcho: begin
                if (pos_after_q) begin ph_nx = PhPos; idx_nx = 3'd0; end
                else seq_last = 1'b1;
            end
            PhHdr: begin
                if (idx_q == 3'd2) begin ph_nx = PhCell; seq_fetch = 1'b1; end
                else idx_nx = idx_q + 3'd1;
            end
            PhCell: begin
                if (ccol_q != LAST_COL) seq_fetch = 1'b1;
                else if (crow_q == LAST_ROW) begin ph_nx = PhPos; idx_nx = 3'd0; end
                else ph_nx = PhCr;
            end
            PhCr: ph_nx = PhLf;
            PhLf: begin ph_nx = PhCell; seq_fetch = 1'b1; end
            PhPos: begin
                if (idx_q == 3'd7) begin
                    seq_last = 1'b1;
                end else begin
                    idx_nx = idx_q + 3'd1;
                    if (idx_nx == 3'd2 && row_num < 8'd10) idx_nx = 3'd3;
                    if (idx_nx == 3'd5 && col_num < 8'd10) idx_nx = 3'd6;
                end
            end
            default: seq_last = 1'b1;
        endcase
    end

    // FSM: state register
    always_ff @(posedge clk) begin
        if (rst) state_q <= StIdle;
        else     state_q <= state_d;
    end

    // FSM: next state; an i_tx_done seen in SEND is ignored
    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle:  if (start) state_d = StSend;
            StFetch: state_d = StSend;
            StSend:  state_d = StWait;
            StWait: begin
                if (i_tx_done) begin
                    if (seq_last)       state_d = StIdle;
                    else if (seq_fetch) state_d = StFetch;
                    else                state_d = StSend;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // FSM: outputs
    always_comb begin
        o_byte   = 8'h00;
        o_byte_v = 1'b0;
        o_busy   = (state_q != StIdle);
        if (state_q == StSend) begin
            o_byte   = cur_byte;
            o_byte_v = 1'b1;
        end
    end

    // Cursor, mode and sequence bookkeeping
    always_ff @(posedge clk) begin
        if (rst) begin
            row_q       <= 7'(CUR_ROW0);
            col_q       <= 7'(CUR_COL0);
            insert_q    <= 1'b0;
            ph_q        <= PhPos;
            idx_q       <= 3'd0;
            pos_after_q <= 1'b0;
            echo_q      <= 8'h00;
            cell_q      <= '0;
            crow_q      <= 7'd0;
            ccol_q      <= 7'd0;
        end else begin
            row_q    <= row_d;
            col_q    <= col_d;
            insert_q <= insert_d;
            if (start) begin
                ph_q        <= ph_start;
                idx_q       <= 3'd0;
                pos_after_q <= pos_after_d;
                echo_q      <= i_byte;
                cell_q      <= '0;
                crow_q      <= 7'd0;
                ccol_q      <= 7'd0;
            end else if (tx_step) begin
                ph_q  <= ph_nx;
                idx_q <= idx_nx;
                if (ph_q == PhCell) begin
                    cell_q <= cell_q + 1'b1;
                    if (ccol_q == LAST_COL) begin
                        ccol_q <= 7'd0;
                        crow_q <= crow_q + 7'd1;
                    end else begin
                        ccol_q <= ccol_q + 7'd1;
                    end
                end
            end
        end
    end

    // Screen RAM, no reset. Writes only happen on an accepted byte in IDLE, while reads
    // only matter in FETCH of a later sequence, so a refresh always sees prior writes.
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_addr] <= i_byte;
        rd_data_q <= mem[cell_q];
    end
endmodule

// File: tb/tb_term_screen_engine.sv
module tb_term_screen_engine;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] i_byte = 8'h00;
    logic       i_byte_v = 1'b0;
    logic       i_tx_done = 1'b0;
    logic [7:0] o_byte;
    logic       o_byte_v, o_busy, o_insert;

    term_screen_engine #(
        .COLS(40), .ROWS(24), .ADDR_W(11), .CUR_ROW0(7), .CUR_COL0(8)
    ) dut (
        .clk(clk), .rst(rst), .i_byte(i_byte), .i_byte_v(i_byte_v), .i_tx_done(i_tx_done),
        .o_byte(o_byte), .o_byte_v(o_byte_v), .o_busy(o_busy), .o_insert(o_insert)
    );

    always #5 clk = ~clk;

    int         n_checks = 0;
    int         n_fail = 0;
    logic [7:0] cap[$];
    logic [7:0] exp_q[$];
    logic [7:0] scr [960];
    int         cur_r, cur_c;
    bit         tx_en = 1'b1;
    bit         spurious = 1'b0;
    bit         outstanding = 1'b0;
    int         pend = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Serializer model: captures bytes and answers with i_tx_done two cycles later.
    initial begin
        forever begin
            @(negedge clk);
            i_tx_done = 1'b0;
            if (o_byte_v) begin
                cap.push_back(o_byte);
                check("one byte in flight", 32'(outstanding), 32'd0);
                outstanding = 1'b1;
                pend = 2;
                if (spurious) i_tx_done = 1'b1;
            end else if (tx_en && pend > 0) begin
                pend--;
                if (pend == 0) begin
                    i_tx_done = 1'b1;
                    outstanding = 1'b0;
                end
            end
        end
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic send(input logic [7:0] b);
        @(negedge clk);
        i_byte = b;
        i_byte_v = 1'b1;
        @(negedge clk);
        i_byte_v = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while (o_busy && n < 20000) begin
            @(negedge clk);
            n++;
        end
        check({tag, " idle in time"}, 32'(n < 20000), 32'd1);
        @(negedge clk);
    endtask

    task automatic push_pos(input int r, input int c);
        exp_q.push_back(8'h1B);
        exp_q.push_back(8'h5B);
        if (r + 1 >= 10) exp_q.push_back(8'(48 + (r + 1) / 10));
        exp_q.push_back(8'(48 + (r + 1) % 10));
        exp_q.push_back(8'h3B);
        if (c + 1 >= 10) exp_q.push_back(8'(48 + (c + 1) / 10));
        exp_q.push_back(8'(48 + (c + 1) % 10));
        exp_q.push_back(8'h48);
    endtask

    task automatic push_refresh();
        exp_q.push_back(8'h1B);
        exp_q.push_back(8'h5B);
        exp_q.push_back(8'h48);
        for (int r = 0; r < 24; r++) begin
            for (int c = 0; c < 40; c++) exp_q.push_back(scr[r * 40 + c]);
            if (r < 23) begin
                exp_q.push_back(8'h0D);
                exp_q.push_back(8'h0A);
            end
        end
        push_pos(cur_r, cur_c);
    endtask

    task automatic cmp_seq(input string tag);
        int n;
        check({tag, " length"}, 32'(cap.size()), 32'(exp_q.size()));
        n = (cap.size() < exp_q.size()) ? cap.size() : exp_q.size();
        for (int i = 0; i < n; i++)
            check($sformatf("%s byte %0d", tag, i), 32'(cap[i]), 32'(exp_q[i]));
        cap.delete();
        exp_q.delete();
    endtask

    task automatic move(input logic [7:0] b, input string tag);
        case (b)
            8'h68: if (cur_c > 0) cur_c--;
            8'h6C: if (cur_c < 39) cur_c++;
            8'h6B: if (cur_r > 0) cur_r--;
            8'h6A: if (cur_r < 23) cur_r++;
            default: ;
        endcase
        cap.delete();
        send(b);
        wait_idle(tag);
        push_pos(cur_r, cur_c);
        cmp_seq(tag);
    endtask

    task automatic do_insert(input logic [7:0] b, input string tag);
        scr[cur_r * 40 + cur_c] = b;
        exp_q.push_back(b);
        if (cur_c == 39) begin
            cur_c = 0;
            cur_r = (cur_r == 23) ? 0 : cur_r + 1;
            push_pos(cur_r, cur_c);
        end else begin
            cur_c++;
        end
        cap.delete();
        send(b);
        wait_idle(tag);
        cmp_seq(tag);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        cur_r = 7;
        cur_c = 8;
    endtask

    // Reset while a byte is outstanding and no tx_done will come.
    task automatic abort_reset(input string tag);
        int sz;
        @(posedge clk);
        tx_en = 1'b0;
        pend = 0;
        outstanding = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check({tag, " busy"}, 32'(o_busy), 32'd0);
        check({tag, " insert"}, 32'(o_insert), 32'd0);
        check({tag, " byte_v"}, 32'(o_byte_v), 32'd0);
        sz = cap.size();
        for (int k = 0; k < 3; k++) begin
            #1 i_tx_done = 1'b1;
            @(negedge clk);
        end
        repeat (30) @(negedge clk);
        check({tag, " no bytes after reset"}, 32'(cap.size()), 32'(sz));
        check({tag, " still idle"}, 32'(o_busy), 32'd0);
        @(posedge clk);
        outstanding = 1'b0;
        pend = 0;
        tx_en = 1'b1;
        cap.delete();
        cur_r = 7;
        cur_c = 8;
    endtask

    initial begin
        int n;
        for (int i = 0; i < 960; i++) scr[i] = 8'h20;
        cur_r = 7;
        cur_c = 8;
        repeat (3) @(negedge clk);
        check("reset o_byte", 32'(o_byte), 32'd0);
        check("reset o_byte_v", 32'(o_byte_v), 32'd0);
        check("reset o_busy", 32'(o_busy), 32'd0);
        check("reset o_insert", 32'(o_insert), 32'd0);
        rst = 1'b0;

        // Bring the screen to all blanks through the insert path (wraps the whole screen).
        send(8'h69);
        check("insert on", 32'(o_insert), 32'd1);
        for (int k = 0; k < 960; k++) do_insert(8'h20, "fill");
        send(8'h1B);
        check("insert off", 32'(o_insert), 32'd0);
        cap.delete();
        send(8'h78);
        repeat (5) @(negedge clk);
        check("ignored byte no output", 32'(cap.size()), 32'd0);
        do_reset();

        // 1: first move, with a tx_done strobe in every SEND cycle that must be ignored
        spurious = 1'b1;
        move(8'h6C, "t1 l");
        spurious = 1'b0;

        // 2: walk to col 0, then clamped move
        for (int k = 0; k < 9; k++) move(8'h68, "t2 h");
        move(8'h68, "t2 h clamp");

        // 3: insert 'A' at cell 288, then refresh
        do_reset();
        send(8'h69);
        do_insert(8'h41, "t3 echo");
        send(8'h1B);
        check("t3 insert off", 32'(o_insert), 32'd0);
        send(8'h20);
        wait_idle("t3 refresh");
        push_refresh();
        cmp_seq("t3 refresh");

        // 4: go to (23,39) with bottom/right clamps, insert wraps to (0,0)
        for (int k = 0; k < 17; k++) move(8'h6A, "t4 j");
        for (int k = 0; k < 31; k++) move(8'h6C, "t4 l");
        send(8'h69);
        do_insert(8'h5A, "t4 wrap");
        send(8'h1B);
        send(8'h20);
        wait_idle("t4 refresh");
        push_refresh();
        cmp_seq("t4 refresh");
        move(8'h6B, "k clamp top");

        // 5: byte arriving while busy is dropped
        cap.delete();
        send(8'h6C);
        send(8'h6A);
        wait_idle("t5");
        cur_c = 1;
        push_pos(0, 1);
        cmp_seq("t5 drop");
        move(8'h6C, "t5 after");

        // 6: reset in the middle of a refresh
        cap.delete();
        send(8'h20);
        n = 0;
        while (cap.size() < 50 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check("t6 refresh started", 32'(cap.size() >= 50), 32'd1);
        abort_reset("t6 refresh");
        move(8'h6C, "t6 move after reset");

        // 6b: reset while an insert echo is outstanding
        do_reset();
        send(8'h69);
        check("t6b insert on", 32'(o_insert), 32'd1);
        @(posedge clk);
        tx_en = 1'b0;
        cap.delete();
        send(8'h51);
        n = 0;
        while (cap.size() == 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("t6b echo seen", 32'(cap.size()), 32'd1);
        abort_reset("t6b echo");
        move(8'h6C, "t6b command mode");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
